// File: rtl/spi_reg_bank_if.sv
// SPI-side bus between the SPI slave and the register bank: completed frames in,
// readback words out.
interface spi_reg_bank_if;
    logic        spi_rx;
    logic [7:0]  spi_address_bits;
    logic [31:0] spi_data_bits;
    logic [31:0] spi_reg_0;
    logic [31:0] spi_reg_1;
    logic [31:0] spi_reg_2;
    logic [31:0] spi_reg_3;

    modport master (
        output spi_rx, spi_address_bits, spi_data_bits,
        input  spi_reg_0, spi_reg_1, spi_reg_2, spi_reg_3
    );

    modport slave (
        input  spi_rx, spi_address_bits, spi_data_bits,
        output spi_reg_0, spi_reg_1, spi_reg_2, spi_reg_3
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Stepper control register bank: commits SPI write frames, double-buffers the step
// period, issues start pulses and tracks a sticky fault plus a saturating error count.
module spi_reg_bank #(
    parameter logic [23:0] PERIOD_RESET = 24'd1000,
    parameter int          ERR_W        = 6
) (
    input  logic                clk,
    input  logic                i_Rst_L,
    spi_reg_bank_if.slave       bus,
    input  logic                i_step_boundary,
    input  logic                i_busy,
    input  logic                i_fault,
    input  logic [23:0]         i_position,
    output logic                o_enable,
    output logic                o_dir,
    output logic [2:0]          o_microstep,
    output logic [23:0]         o_period,
    output logic [23:0]         o_target_steps,
    output logic                o_start,
    output logic                o_fault_sticky
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic             spi_rx_q;
    logic [23:0]      shadow;
    logic [ERR_W-1:0] err_cnt;

    logic             wr_stb;
    logic [6:0]       addr;
    logic [31:0]      data;
    logic             enable_n, dir_n, start_n, fault_n, clear, err_inc;
    logic [2:0]       microstep_n;
    logic [23:0]      shadow_n, period_n, target_n;
    logic [ERR_W-1:0] err_n;

    always_comb begin
        wr_stb      = bus.spi_rx & ~spi_rx_q & bus.spi_address_bits[7];
        addr        = bus.spi_address_bits[6:0];
        data        = bus.spi_data_bits;
        enable_n    = o_enable;
        dir_n       = o_dir;
        microstep_n = o_microstep;
        shadow_n    = shadow;
        target_n    = o_target_steps;
        start_n     = 1'b0;
        clear       = 1'b0;
        err_inc     = 1'b0;
        if (wr_stb) begin
            case (addr)
                7'd0: begin
                    enable_n    = data[0];
                    dir_n       = data[1];
                    microstep_n = data[4:2];
                    clear       = data[9];
                    // A start request with the move disabled is dropped without error.
                    if (data[8] && data[0]) begin
                        if (i_busy) err_inc = 1'b1;
                        else        start_n = 1'b1;
                    end
                end
                7'd1: shadow_n = (data[23:0] == 24'd0) ? 24'd1 : data[23:0];
                7'd2: begin
                    if (i_busy) err_inc  = 1'b1;
                    else        target_n = data[23:0];
                end
                default: err_inc = 1'b1;
            endcase
        end
        // Active period takes the pre-write shadow, so a coincident write waits a boundary.
        period_n = (i_step_boundary || !i_busy) ? shadow : o_period;
        fault_n  = i_fault | (o_fault_sticky & ~clear);
        if (clear)        err_n = '0;
        else if (err_inc) err_n = sat_inc(err_cnt);
        else              err_n = err_cnt;
    end

    always_ff @(posedge clk) begin
        if (!i_Rst_L) begin
            spi_rx_q       <= 1'b1;
            o_enable       <= 1'b0;
            o_dir          <= 1'b0;
            o_microstep    <= 3'd0;
            shadow         <= PERIOD_RESET;
            o_period       <= PERIOD_RESET;
            o_target_steps <= 24'd0;
            o_start        <= 1'b0;
            o_fault_sticky <= 1'b0;
            err_cnt        <= '0;
            bus.spi_reg_0  <= 32'd0;
            bus.spi_reg_1  <= 32'd0;
            bus.spi_reg_2  <= 32'd0;
            bus.spi_reg_3  <= 32'd0;
        end else begin
            spi_rx_q       <= bus.spi_rx;
            o_enable       <= enable_n;
            o_dir          <= dir_n;
            o_microstep    <= microstep_n;
            shadow         <= shadow_n;
            o_period       <= period_n;
            o_target_steps <= target_n;
            o_start        <= start_n;
            o_fault_sticky <= fault_n;
            err_cnt        <= err_n;
            bus.spi_reg_0  <= {27'd0, microstep_n, dir_n, enable_n};
            bus.spi_reg_1  <= {8'd0, shadow_n};
            bus.spi_reg_2  <= {8'd0, target_n};
            bus.spi_reg_3  <= {i_busy, fault_n, 6'(err_n), i_position};
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank with hand-computed expectations.
module tb_spi_reg_bank;

    logic        clk;
    logic        rst_l;
    logic        step_boundary, busy, fault;
    logic [23:0] position;
    logic        enable, dir, start, fault_sticky;
    logic [2:0]  microstep;
    logic [23:0] period, target_steps;

    int passed = 0;
    int total  = 0;

    spi_reg_bank_if bus ();

    spi_reg_bank dut (
        .clk             (clk),
        .i_Rst_L         (rst_l),
        .bus             (bus),
        .i_step_boundary (step_boundary),
        .i_busy          (busy),
        .i_fault         (fault),
        .i_position      (position),
        .o_enable        (enable),
        .o_dir           (dir),
        .o_microstep     (microstep),
        .o_period        (period),
        .o_target_steps  (target_steps),
        .o_start         (start),
        .o_fault_sticky  (fault_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic frame_start(input logic [7:0] a, input logic [31:0] d);
        bus.spi_address_bits = a;
        bus.spi_data_bits    = d;
        bus.spi_rx           = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        bus.spi_rx = 1'b0;
        tick();
    endtask

    initial begin
        rst_l                = 1'b0;
        bus.spi_rx           = 1'b1;
        bus.spi_address_bits = 8'h80;
        bus.spi_data_bits    = 32'h105;
        step_boundary        = 1'b0;
        busy                 = 1'b0;
        fault                = 1'b0;
        position             = 24'h123456;
        repeat (3) tick();

        // Reset state
        chk("rst_period", 32'(period), 32'd1000);
        chk("rst_reg0", bus.spi_reg_0, 32'd0);
        chk("rst_reg1", bus.spi_reg_1, 32'd0);
        chk("rst_reg2", bus.spi_reg_2, 32'd0);
        chk("rst_reg3", bus.spi_reg_3, 32'd0);
        chk("rst_start_en", {30'd0, start, enable}, 32'd0);

        // Reset exit with spi_rx held high: no commit
        rst_l = 1'b1;
        repeat (3) tick();
        chk("exit_start", 32'(start), 32'd0);
        chk("exit_enable", 32'(enable), 32'd0);
        chk("exit_reg1", bus.spi_reg_1, 32'd1000);
        chk("exit_period", 32'(period), 32'd1000);
        frame_end();

        // CTRL write with start while idle
        frame_start(8'h80, 32'h105);
        chk("ctrl_start", 32'(start), 32'd1);
        chk("ctrl_en", 32'(enable), 32'd1);
        chk("ctrl_ms", 32'(microstep), 32'd1);
        chk("ctrl_reg0", bus.spi_reg_0, 32'h5);
        frame_end();
        chk("ctrl_start_drop", 32'(start), 32'd0);

        // Double-buffered period while busy
        busy = 1'b1;
        tick();
        frame_start(8'h81, 32'd500);
        chk("per_shadow", bus.spi_reg_1, 32'd500);
        chk("per_hold", 32'(period), 32'd1000);
        frame_end();
        tick();
        chk("per_hold2", 32'(period), 32'd1000);
        step_boundary = 1'b1;
        tick();
        step_boundary = 1'b0;
        chk("per_load", 32'(period), 32'd500);
        frame_start(8'h81, 32'd600);
        frame_end();
        chk("per_hold600", 32'(period), 32'd500);
        step_boundary = 1'b1;
        frame_start(8'h81, 32'd300);
        step_boundary = 1'b0;
        chk("per_coinc_old", 32'(period), 32'd600);
        chk("per_coinc_shadow", bus.spi_reg_1, 32'd300);
        frame_end();
        chk("per_coinc_hold", 32'(period), 32'd600);
        step_boundary = 1'b1;
        tick();
        step_boundary = 1'b0;
        chk("per_coinc_next", 32'(period), 32'd300);

        // Busy-rejected writes
        frame_start(8'h82, 32'd77);
        chk("tgt_busy_drop", 32'(target_steps), 32'd0);
        frame_end();
        frame_start(8'h80, 32'h101);
        chk("start_busy_drop", 32'(start), 32'd0);
        frame_end();
        chk("err_two", bus.spi_reg_3, 32'h82123456);
        busy = 1'b0;
        frame_start(8'h82, 32'd77);
        chk("tgt_idle", 32'(target_steps), 32'd77);
        chk("tgt_reg2", bus.spi_reg_2, 32'd77);
        frame_end();

        // Error counter saturation, then fault set wins over clear
        for (int i = 0; i < 70; i++) begin
            frame_start(8'h85, 32'd0);
            frame_end();
        end
        chk("err_sat", 32'(bus.spi_reg_3[29:24]), 32'd63);
        fault = 1'b1;
        frame_start(8'h80, 32'h201);
        fault = 1'b0;
        chk("fault_set_wins", 32'(fault_sticky), 32'd1);
        chk("clear_err", 32'(bus.spi_reg_3[30:24]), 32'h40);
        frame_end();
        frame_start(8'h80, 32'h201);
        chk("clear_fault", 32'(fault_sticky), 32'd0);
        frame_end();

        // Long spi_rx high gives one commit; period 0 stored as 1
        bus.spi_address_bits = 8'h85;
        bus.spi_rx           = 1'b1;
        repeat (10) tick();
        frame_end();
        chk("one_commit", 32'(bus.spi_reg_3[29:24]), 32'd1);
        frame_start(8'h81, 32'd0);
        chk("zero_period_shadow", bus.spi_reg_1, 32'd1);
        frame_end();
        chk("zero_period_active", 32'(period), 32'd1);

        // Reset mid-frame, release with spi_rx still high
        bus.spi_address_bits = 8'h85;
        bus.spi_rx           = 1'b1;
        rst_l                = 1'b0;
        tick();
        chk("midrst_reg3", bus.spi_reg_3, 32'd0);
        rst_l = 1'b1;
        repeat (3) tick();
        chk("midrst_no_commit", 32'(bus.spi_reg_3[29:24]), 32'd0);
        chk("midrst_period", 32'(period), 32'd1000);
        frame_end();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
